// File: rtl/frame_step_monitor.sv
// Step/frame toggle monitor: step count, edge-to-edge period,
// 8-deep moving average and stall detection.
module frame_step_monitor #(
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 500000,
  parameter int AVG_LOG2 = 3
) (
  input  logic             CLOCK,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             step_in,
  output logic [31:0]      step_count,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] period_avg,
  output logic             new_period,
  output logic             avg_valid,
  output logic             running,
  output logic             stall
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0] ONE  = (AVG_LOG2 + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_MEAS  = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic [1:0]       state;
  logic             s_meta, sync_q, sync_qq;
  logic             ev;
  logic [CNT_W-1:0] timer, timer_inc;
  logic [CNT_W-1:0] hist [DEPTH];
  logic [SUM_W-1:0] sum, new_sum;
  logic [CNT_W-1:0] avg_next;
  logic [AVG_LOG2:0] hist_cnt;
  logic             hist_push, hist_clr, to_stall;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      s_meta  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
    end else begin
      s_meta  <= step_in;
      sync_q  <= s_meta;
      sync_qq <= sync_q;
    end
  end

  assign ev        = sync_q ^ sync_qq;
  assign timer_inc = (timer >= TMAX) ? TMAX : timer + 1'b1;
  assign new_sum   = sum + SUM_W'(timer) - SUM_W'(hist[DEPTH-1]);
  assign avg_next  = CNT_W'(new_sum >> AVG_LOG2);

  always_comb begin
    hist_push = enable && !clr && ev && (state == S_MEAS);
    to_stall  = enable && !clr && !ev && (state == S_MEAS)
                && (timer == TMAX);
    hist_clr  = !enable || clr || to_stall;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      step_count <= '0;
      period     <= '0;
      period_avg <= '0;
      new_period <= 1'b0;
      running    <= 1'b0;
      stall      <= 1'b0;
    end else begin
      new_period <= 1'b0;
      if (!enable) begin
        state   <= S_IDLE;
        timer   <= '0;
        running <= 1'b0;
        stall   <= 1'b0;
        if (clr) begin
          step_count <= '0;
          period     <= '0;
          period_avg <= '0;
        end
      end else if (clr) begin
        step_count <= '0;
        period     <= '0;
        period_avg <= '0;
        timer      <= '0;
        running    <= 1'b0;
        stall      <= 1'b0;
        if (state != S_IDLE) state <= S_ARM;
      end else begin
        unique case (state)
          S_IDLE: begin
            timer <= '0;
            state <= S_ARM;
          end
          S_ARM: begin
            if (ev) begin
              step_count <= step_count + 1'b1;
              timer      <= CNT_W'(1);
              running    <= 1'b1;
              state      <= S_MEAS;
            end else begin
              timer <= timer_inc;
            end
          end
          S_MEAS: begin
            if (ev) begin
              step_count <= step_count + 1'b1;
              timer      <= CNT_W'(1);
              period     <= timer;
              period_avg <= avg_next;
              new_period <= 1'b1;
            end else if (timer == TMAX) begin
              running <= 1'b0;
              stall   <= 1'b1;
              state   <= S_STALL;
            end else begin
              timer <= timer_inc;
            end
          end
          S_STALL: begin
            if (ev) begin
              step_count <= step_count + 1'b1;
              timer      <= CNT_W'(1);
              running    <= 1'b1;
              stall      <= 1'b0;
              state      <= S_MEAS;
            end else begin
              timer <= timer_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // History shifts newest into [0]; [DEPTH-1] is the sample leaving the sum
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum       <= '0;
      hist_cnt  <= '0;
      avg_valid <= 1'b0;
    end else if (hist_clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum       <= '0;
      hist_cnt  <= '0;
      avg_valid <= 1'b0;
    end else if (hist_push) begin
      hist[0] <= timer;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      sum <= new_sum;
      if (hist_cnt != FULL) hist_cnt <= hist_cnt + ONE;
      if (hist_cnt == FULL - ONE) avg_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_step_monitor.sv
// Scoreboard bench for frame_step_monitor: expected period/avg
// queued at each toggle, checked on every new_period pulse.
module tb_frame_step_monitor;

  localparam int CNT_W = 32;
  localparam int TOUT  = 300;

  logic             CLOCK = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             clr = 1'b0;
  logic             step_in = 1'b0;
  logic [31:0]      step_count;
  logic [CNT_W-1:0] period, period_avg;
  logic             new_period, avg_valid, running, stall;

  int checks = 0;
  int errors = 0;
  int np_count = 0;
  longint cyc = 0;
  longint last_tog = 0;

  int unsigned q_per [$];
  int unsigned q_avg [$];
  int unsigned m_hist [$];

  frame_step_monitor #(.CNT_W(CNT_W), .TIMEOUT(TOUT), .AVG_LOG2(3)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .enable(enable), .clr(clr),
    .step_in(step_in), .step_count(step_count), .period(period),
    .period_avg(period_avg), .new_period(new_period),
    .avg_valid(avg_valid), .running(running), .stall(stall)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (rst_n && new_period) begin
      np_count = np_count + 1;
      checks = checks + 1;
      if (q_per.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_new_period period=%0d avg=%0d",
                 period, period_avg);
      end else begin
        int unsigned ep, ea;
        ep = q_per.pop_front();
        ea = q_avg.pop_front();
        if (period !== ep || period_avg !== ea) begin
          errors = errors + 1;
          $display("FAIL period_sample got %0d/%0d exp %0d/%0d",
                   period, period_avg, ep, ea);
        end
      end
    end
  end

  task automatic model_clear();
    m_hist.delete();
  endtask

  task automatic model_push(input int unsigned p);
    int unsigned s;
    m_hist.push_front(p);
    if (m_hist.size() > 8) void'(m_hist.pop_back());
    s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    q_per.push_back(p);
    q_avg.push_back(s >> 3);
  endtask

  task automatic edge_exp(input int gap, input bit rec);
    while (cyc - last_tog < gap) @(negedge CLOCK);
    if (rec) model_push(int'(cyc - last_tog));
    step_in = ~step_in;
    last_tog = cyc;
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic settle();
    repeat (5) @(negedge CLOCK);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK);
    rst_n = 1'b1;
    model_clear();
    q_per.delete();
    q_avg.delete();
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    rst_n = 1'b0;
    @(negedge CLOCK);
    chk("rst_step_count", step_count, 0);
    chk("rst_period", period, 0);
    chk("rst_avg", period_avg, 0);
    chk("rst_flags", {new_period, avg_valid, running, stall}, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_steady();
    enable = 1'b1;
    repeat (3) @(negedge CLOCK);
    np_count = 0;
    edge_exp(100, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      edge_exp(100, 1'b1);
      settle();
      if (i == 8) chk("avg_valid_before_9th", avg_valid, 0);
      if (i == 9) chk("avg_valid_at_9th", avg_valid, 1);
    end
    chk("steady_step_count", step_count, 10);
    chk("steady_pulses", np_count, 9);
    chk("steady_period", period, 100);
    chk("steady_avg", period_avg, 100);
    chk("steady_running", running, 1);
  endtask

  task automatic test_avg_step();
    do_reset();
    repeat (3) @(negedge CLOCK);
    edge_exp(100, 1'b0);
    for (int i = 0; i < 8; i++) edge_exp(100, 1'b1);
    for (int i = 0; i < 8; i++) edge_exp(200, 1'b1);
    settle();
    chk("avg_after_200s", period_avg, 200);
    chk("avg_step_count", step_count, 17);
  endtask

  task automatic test_stall();
    int k;
    edge_exp(200, 1'b1);
    k = 0;
    while (!new_period && k < 10) begin
      @(negedge CLOCK);
      k++;
    end
    chk("stall_pulse_seen", new_period, 1);
    k = 0;
    while (!stall && k < TOUT + 50) begin
      @(negedge CLOCK);
      k++;
    end
    chk("stall_latency", k, TOUT);
    chk("stall_running", running, 0);
    chk("stall_avg_valid", avg_valid, 0);
    chk("stall_period_held", period, 200);
    model_clear();
    edge_exp(0, 1'b0);
    settle();
    chk("unstall", stall, 0);
    chk("unstall_running", running, 1);
    edge_exp(100, 1'b1);
    settle();
    chk("post_stall_period", period, 100);
  endtask

  task automatic test_clr_ev();
    edge_exp(100, 1'b0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    clr = 1'b1;
    @(negedge CLOCK);
    clr = 1'b0;
    model_clear();
    settle();
    chk("clr_step_count", step_count, 0);
    chk("clr_period", period, 0);
    chk("clr_avg", period_avg, 0);
    chk("clr_arm", {running, stall}, 0);
    edge_exp(100, 1'b0);
    settle();
    chk("clr_first_edge", step_count, 1);
    edge_exp(100, 1'b1);
    settle();
    chk("clr_second_edge", step_count, 2);
    chk("clr_period_rec", period, 100);
  endtask

  task automatic test_enable();
    @(negedge CLOCK);
    enable = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("dis_running", running, 0);
    chk("dis_avg_valid", avg_valid, 0);
    model_clear();
    for (int i = 0; i < 3; i++) edge_exp(20, 1'b0);
    settle();
    chk("dis_step_held", step_count, 2);
    chk("dis_period_held", period, 100);
    enable = 1'b1;
    repeat (3) @(negedge CLOCK);
    edge_exp(30, 1'b0);
    settle();
    chk("reen_first_edge", step_count, 3);
    edge_exp(100, 1'b1);
    settle();
    chk("reen_step", step_count, 4);
  endtask

  task automatic test_reset_wrap();
    repeat (30) @(negedge CLOCK);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_step_count", step_count, 0);
    chk("arst_period", period, 0);
    chk("arst_avg", period_avg, 0);
    chk("arst_flags", {new_period, avg_valid, running, stall}, 0);
    @(negedge CLOCK);
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(negedge CLOCK);
    force dut.step_count = 32'hFFFF_FFFE;
    @(negedge CLOCK);
    release dut.step_count;
    edge_exp(10, 1'b0);
    settle();
    chk("wrap_max", step_count, 32'hFFFF_FFFF);
    edge_exp(100, 1'b1);
    settle();
    chk("wrap_zero", step_count, 0);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_avg_step();
    test_stall();
    test_clr_ev();
    test_enable();
    test_reset_wrap();
    settle();
    chk("scoreboard_empty", q_per.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d exp finish", cyc);
    $fatal(1);
  end

endmodule
